// File: rtl/alu_mc.sv
// alu_mc: parametrised ALU with registered result/flags and an iterative shift-add multiplier
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] inputa_i,
  input  logic [WIDTH-1:0] inputb_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] out_o,
  output logic             carry_o,
  output logic             zero_o
);
  localparam int SW = $clog2(WIDTH);
  typedef enum logic {IDLE, MUL} state_t;
  state_t state_q, state_d;
  logic [2*WIDTH-1:0] ma_q, ma_d, acc_q, acc_d;
  logic [WIDTH-1:0] mb_q, mb_d, out_q, out_d, res;
  logic [SW-1:0] cnt_q, cnt_d, sh;
  logic carry_q, carry_d, zero_q, zero_d, done_q, done_d, cy;
  logic [WIDTH:0] sum, shl, shr;
  always_comb begin
    sh = inputb_i[SW-1:0];
    sum = {1'b0, inputa_i} + {1'b0, inputb_i} + {{WIDTH{1'b0}}, (op_i == 3'd6) & carry_q};
    // the extra bit catches the last bit shifted out; a zero shift leaves it 0
    shl = {1'b0, inputa_i} << sh;
    shr = {inputa_i, 1'b0} >> sh;
    res = '0;
    cy = 1'b0;
    case (op_i)
      3'd0, 3'd6: {cy, res} = sum;
      3'd1: res = inputa_i ^ inputb_i;
      3'd2: {cy, res} = shl;
      3'd3: {res, cy} = shr;
      3'd4: res = {{(WIDTH-1){1'b0}}, |inputa_i};
      3'd5: res = {{(WIDTH-1){1'b0}}, ~|inputa_i};
      default: ;
    endcase
    state_d = state_q;
    ma_d = ma_q;
    mb_d = mb_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    out_d = out_q;
    carry_d = carry_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (start_i && op_i == 3'd7) begin
        state_d = MUL;
        ma_d = {{WIDTH{1'b0}}, inputa_i};
        mb_d = inputb_i;
        acc_d = '0;
        cnt_d = '0;
      end else if (start_i) begin
        out_d = res;
        carry_d = cy;
        done_d = 1'b1;
      end
    end else begin
      acc_d = acc_q + (mb_q[0] ? ma_q : '0);
      ma_d = ma_q << 1;
      mb_d = mb_q >> 1;
      cnt_d = cnt_q + SW'(1);
      if (cnt_q == SW'(WIDTH - 1)) begin
        out_d = acc_d[WIDTH-1:0];
        carry_d = |acc_d[2*WIDTH-1:WIDTH];
        done_d = 1'b1;
        state_d = IDLE;
      end
    end
    zero_d = (out_d == '0);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ma_q <= '0;
      mb_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
      carry_q <= 1'b0;
      zero_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ma_q <= ma_d;
      mb_q <= mb_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      out_q <= out_d;
      carry_q <= carry_d;
      zero_q <= zero_d;
      done_q <= done_d;
    end
  end
  assign busy_o = (state_q == MUL);
  assign done_o = done_q;
  assign out_o = out_q;
  assign carry_o = carry_q;
  assign zero_o = zero_q;
endmodule
